// File: rtl/frame_buffer_scanout.sv
// rtl/frame_buffer_scanout.sv - double-buffered 8-column 1-bit framebuffer with row scanout
//
// Purpose:
//   Captures a 4-bit pixel nibble stream (framed by frame_sync) into a back
//   buffer, then replays the completed front buffer continuously as 8-bit
//   rows over a valid/ready stream. Front/back swap happens only at a
//   scanout frame boundary, so output frames never tear.
//
// Optional feature macro: FB_DROP_CNT_EN
//   When defined, adds drop_cnt[7:0], a saturating count of dropped frames.
//
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   pixel_data[3:0]   - pixel nibble, bit0 = leftmost pixel of the nibble
//   pixel_valid       - pixel_data qualifier
//   frame_sync        - start-of-frame marker, qualified by pixel_valid
//   row_data[7:0]     - scanout row, bit0 = column 0
//   row_idx           - row number of row_data
//   row_sof           - high while row 0 is presented
//   row_valid         - scanout valid
//   row_ready         - scanout ready
//   frame_avail       - front buffer holds a complete frame
//   overflow          - sticky, an input frame was dropped
//   drop_cnt[7:0]     - dropped frame count (FB_DROP_CNT_EN only)

module frame_buffer_scanout #(
    parameter int ROWS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              pixel_data,
    input  logic                    pixel_valid,
    input  logic                    frame_sync,
    output logic [7:0]              row_data,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic                    row_sof,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic                    frame_avail,
`ifdef FB_DROP_CNT_EN
    output logic [7:0]              drop_cnt,
`endif
    output logic                    overflow
);

    localparam int NIB_PER_FRAME = 2 * ROWS;
    localparam int RW            = $clog2(ROWS);
    localparam int NW            = $clog2(NIB_PER_FRAME);

    typedef enum logic [1:0] {
        C_IDLE,
        C_FILL,
        C_WAIT
    } cap_state_t;

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } scan_state_t;

    cap_state_t        c_state_q, c_state_d;
    scan_state_t       s_state_q, s_state_d;
    logic [NW-1:0]     nib_cnt_q, nib_cnt_d;
    logic              swap_pending_q, swap_pending_d;
    logic              frame_avail_q, frame_avail_d;
    logic              overflow_q, overflow_d;
    logic [RW-1:0]     row_idx_q, row_idx_d;
    logic [7:0]        back_q  [ROWS];
    logic [7:0]        back_d  [ROWS];
    logic [7:0]        front_q [ROWS];
    logic [7:0]        front_d [ROWS];
`ifdef FB_DROP_CNT_EN
    logic [7:0]        drop_cnt_q, drop_cnt_d;
`endif

    logic              accept_sync;
    logic              last_row_hs;
    logic              swap_fire;
    logic              drop_evt;
    logic              wr_en;
    logic [NW-1:0]     wr_nib;

    assign accept_sync = pixel_valid & frame_sync;

    // The frame boundary seen by the consumer: the last row is being taken.
    assign last_row_hs = (s_state_q == S_SCAN) && row_ready && (row_idx_q == RW'(ROWS - 1));

    // swap_pending_q is only visible the cycle after the final nibble, so a
    // final nibble coinciding with last_row_hs naturally defers to the next
    // frame boundary.
    assign swap_fire = swap_pending_q && ((s_state_q == S_IDLE) || last_row_hs);

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    always_comb begin
        c_state_d      = c_state_q;
        nib_cnt_d      = nib_cnt_q;
        swap_pending_d = swap_pending_q;
        drop_evt       = 1'b0;
        wr_en          = 1'b0;
        wr_nib         = '0;

        case (c_state_q)
            C_IDLE: begin
                if (accept_sync) begin
                    wr_en     = 1'b1;
                    wr_nib    = '0;
                    nib_cnt_d = NW'(1);
                    c_state_d = C_FILL;
                end
            end
            C_FILL: begin
                if (pixel_valid) begin
                    wr_en = 1'b1;
                    if (frame_sync) begin
                        // Restart: stale nibbles are overwritten as the new
                        // frame arrives, no explicit clear needed.
                        wr_nib    = '0;
                        nib_cnt_d = NW'(1);
                    end else begin
                        wr_nib = nib_cnt_q;
                        if (nib_cnt_q == NW'(NIB_PER_FRAME - 1)) begin
                            nib_cnt_d      = '0;
                            swap_pending_d = 1'b1;
                            c_state_d      = C_WAIT;
                        end else begin
                            nib_cnt_d = nib_cnt_q + NW'(1);
                        end
                    end
                end
            end
            C_WAIT: begin
                if (accept_sync) begin
                    drop_evt = 1'b1;
                end
                if (swap_fire) begin
                    swap_pending_d = 1'b0;
                    c_state_d      = C_IDLE;
                end
            end
            default: begin
                c_state_d = C_IDLE;
            end
        endcase
    end

    always_comb begin
        overflow_d = overflow_q | drop_evt;
    end

`ifdef FB_DROP_CNT_EN
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_evt && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end
`endif

    // Back buffer write: nibble n lands in row n>>1, odd nibbles in the high half.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            back_d[r] = back_q[r];
        end
        if (wr_en) begin
            if (wr_nib[0]) begin
                back_d[wr_nib[NW-1:1]][7:4] = pixel_data;
            end else begin
                back_d[wr_nib[NW-1:1]][3:0] = pixel_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scanout FSM and front buffer
    // ------------------------------------------------------------------
    always_comb begin
        s_state_d     = s_state_q;
        row_idx_d     = row_idx_q;
        frame_avail_d = frame_avail_q;
        for (int r = 0; r < ROWS; r++) begin
            front_d[r] = front_q[r];
        end

        case (s_state_q)
            S_IDLE: begin
                if (swap_fire) begin
                    s_state_d = S_SCAN;
                    row_idx_d = '0;
                end
            end
            S_SCAN: begin
                if (row_ready) begin
                    row_idx_d = (row_idx_q == RW'(ROWS - 1)) ? '0 : row_idx_q + RW'(1);
                end
            end
            default: begin
                s_state_d = S_IDLE;
            end
        endcase

        if (swap_fire) begin
            frame_avail_d = 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                front_d[r] = back_q[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_state_q      <= C_IDLE;
            s_state_q      <= S_IDLE;
            nib_cnt_q      <= '0;
            swap_pending_q <= 1'b0;
            frame_avail_q  <= 1'b0;
            overflow_q     <= 1'b0;
            row_idx_q      <= '0;
            for (int r = 0; r < ROWS; r++) begin
                back_q[r]  <= '0;
                front_q[r] <= '0;
            end
        end else begin
            c_state_q      <= c_state_d;
            s_state_q      <= s_state_d;
            nib_cnt_q      <= nib_cnt_d;
            swap_pending_q <= swap_pending_d;
            frame_avail_q  <= frame_avail_d;
            overflow_q     <= overflow_d;
            row_idx_q      <= row_idx_d;
            for (int r = 0; r < ROWS; r++) begin
                back_q[r]  <= back_d[r];
                front_q[r] <= front_d[r];
            end
        end
    end

`ifdef FB_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    // Front only changes on a swap, which cannot happen while a row is
    // stalled mid-frame, so row_data is stable under backpressure.
    assign row_valid   = (s_state_q == S_SCAN);
    assign row_idx     = row_idx_q;
    assign row_sof     = row_valid && (row_idx_q == '0);
    assign row_data    = front_q[row_idx_q];
    assign frame_avail = frame_avail_q;
    assign overflow    = overflow_q;

endmodule
